// File: rtl/alu_dispatch.sv
// alu_dispatch: FIFO-buffered command issuer keeping one operation outstanding in the alu
module alu_dispatch #(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_cmd,
  output logic        o_ready,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [3:0]  o_alu_cmd,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_valid,
  input  logic        i_alu_ready,
  output logic [31:0] o_result,
  output logic [3:0]  o_cmd,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_timeout,
  output logic [15:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_nx;
  logic [67:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [15:0] timer;
  logic [3:0]  issued_cmd;
  logic empty, full, push, pop, issue_done, capture, expire, accept;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_ready = !full;
  assign push = i_valid && !full && i_cmd != 4'h0;
  // State register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // Per-state events; conditions are mutually exclusive because each belongs to one state
  always_comb begin
    pop = state == IDLE && !empty;
    issue_done = state == ISSUE && i_alu_ready;
    capture = state == WAIT && i_alu_valid;
    expire = state == WAIT && !i_alu_valid && timer == 16'(TIMEOUT - 1);
    accept = state == HOLD && i_ready;
  end
  // Next-state selection from the event that fires in the current state
  always_comb begin
    state_nx = pop ? ISSUE : issue_done ? WAIT : capture ? HOLD : (expire || accept) ? IDLE : state;
  end
  // FIFO storage; NOP commands never reach it
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {i_a, i_b, i_cmd};
  // Pointers, alu drive, watchdog, result capture and completion counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_alu_a <= '0;
      o_alu_b <= '0;
      o_alu_cmd <= 4'h0;
      issued_cmd <= 4'h0;
      timer <= '0;
      o_result <= '0;
      o_cmd <= 4'h0;
      o_valid <= 1'b0;
      o_timeout <= 1'b0;
      o_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {o_alu_a, o_alu_b, o_alu_cmd} <= mem[rd_ptr[AW-1:0]];
        issued_cmd <= mem[rd_ptr[AW-1:0]][3:0];
      end
      if (issue_done) begin
        o_alu_cmd <= 4'h0;
        timer <= '0;
      end
      if (state == WAIT && !i_alu_valid) timer <= timer + 16'd1;
      if (capture) begin
        o_result <= i_alu_result;
        o_cmd <= issued_cmd;
        o_valid <= 1'b1;
      end
      if (expire) o_timeout <= 1'b1;
      if (accept) begin
        o_valid <= 1'b0;
        o_count <= o_count + 16'd1;
      end
    end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: randomized and directed checks of alu_dispatch against a queue-based reference
module tb_alu_dispatch;
  localparam logic [3:0] SHL = 4'h5;
  logic clk = 1'b0, reset = 1'b0;
  logic i_valid = 1'b0, i_ready = 1'b0, i_alu_ready = 1'b0;
  logic [31:0] i_a = '0, i_b = '0;
  logic [3:0] i_cmd = 4'h0;
  logic o_ready, o_valid, o_timeout;
  logic [31:0] o_alu_a, o_alu_b, o_result, i_alu_result;
  logic [3:0] o_alu_cmd, o_cmd;
  logic [15:0] o_count;
  logic i_alu_valid;
  logic mv = 1'b0, jv = 1'b0, busy = 1'b0, mute = 1'b0;
  logic [31:0] mres = '0, jres = '0, ra = '0, rb = '0;
  int cnt = 0, fix_lat = 0, issues = 0;
  int n_cmp = 0, n_err = 0;
  logic [35:0] exp_q[$];
  logic [15:0] exp_count = '0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  assign i_alu_valid = mv | jv;
  assign i_alu_result = jv ? jres : mres;

  alu_dispatch #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_a(i_a), .i_b(i_b), .i_cmd(i_cmd),
    .o_ready(o_ready), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_cmd(o_alu_cmd),
    .i_alu_result(i_alu_result), .i_alu_valid(i_alu_valid), .i_alu_ready(i_alu_ready),
    .o_result(o_result), .o_cmd(o_cmd), .o_valid(o_valid), .i_ready(i_ready),
    .o_timeout(o_timeout), .o_count(o_count)
  );

  // Stand-in ALU: accepts an opcode when ready, answers a << b after a short latency
  always @(posedge clk or negedge reset)
    if (!reset) begin
      busy <= 1'b0;
      mv <= 1'b0;
      cnt <= 0;
    end else begin
      mv <= 1'b0;
      if (o_alu_cmd != 4'h0 && i_alu_ready) issues <= issues + 1;
      if (busy) begin
        if (cnt == 0) begin
          mv <= 1'b1;
          mres <= ra << rb[4:0];
          busy <= 1'b0;
        end else cnt <= cnt - 1;
      end else if (o_alu_cmd != 4'h0 && i_alu_ready && !mute) begin
        busy <= 1'b1;
        ra <= o_alu_a;
        rb <= o_alu_b;
        cnt <= (fix_lat > 0 ? fix_lat : int'($urandom_range(1, 4))) - 1;
      end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_check();
    logic [35:0] e;
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) chk("unexpected_valid", {31'b0, o_valid}, 32'h0);
      else begin
        e = exp_q.pop_front();
        chk("result", o_result, e[35:4]);
        chk("cmd", {28'b0, o_cmd}, {28'b0, e[3:0]});
        last_res = e[35:4];
        exp_count++;
      end
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                      input bit track, output bit ok);
    i_valid = 1'b1; i_a = a; i_b = b; i_cmd = c;
    ok = o_ready;
    if (ok && track && c != 4'h0) exp_q.push_back({a << b[4:0], c});
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    i_ready = 1'b1;
    while (exp_q.size() > 0 && n < 2000) begin
      step_check();
      @(negedge clk);
      n++;
    end
    chk({tag, "_left"}, exp_q.size(), 32'h0);
    chk({tag, "_count"}, {16'b0, o_count}, {16'b0, exp_count});
    i_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    int n, acc, sent, i0;
    logic [15:0] c0;
    // Reset held low while every input toggles
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      i_valid = $urandom_range(0, 1); i_a = $urandom; i_b = $urandom; i_cmd = 4'($urandom);
      i_ready = $urandom_range(0, 1); i_alu_ready = $urandom_range(0, 1);
      jv = $urandom_range(0, 1); jres = $urandom;
    end
    chk("rst_ready", {31'b0, o_ready}, 32'h1);
    chk("rst_alu_a", o_alu_a, 32'h0);
    chk("rst_alu_b", o_alu_b, 32'h0);
    chk("rst_alu_cmd", {28'b0, o_alu_cmd}, 32'h0);
    chk("rst_result", o_result, 32'h0);
    chk("rst_cmd", {28'b0, o_cmd}, 32'h0);
    chk("rst_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_timeout", {31'b0, o_timeout}, 32'h0);
    chk("rst_count", {16'b0, o_count}, 32'h0);
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b0; i_alu_ready = 1'b1; jv = 1'b0; i_cmd = 4'h0;
    reset = 1'b1;
    @(negedge clk);
    // Single op: 1 << 5 with fixed alu latency, result held until consumer accepts
    fix_lat = 2;
    push(32'h1, 32'h5, SHL, 1'b1, ok);
    n = 0;
    while (!o_valid && n < 40) begin @(negedge clk); n++; end
    chk("single_valid", {31'b0, o_valid}, 32'h1);
    chk("single_res", o_result, 32'h20);
    chk("single_cmd", {28'b0, o_cmd}, {28'b0, SHL});
    repeat (3) @(negedge clk);
    chk("single_hold", {31'b0, o_valid}, 32'h1);
    chk("single_stable", o_result, 32'h20);
    i_ready = 1'b1;
    step_check();
    @(negedge clk);
    i_ready = 1'b0;
    chk("single_drop", {31'b0, o_valid}, 32'h0);
    chk("single_count", {16'b0, o_count}, 32'h1);
    // ALU valid while idle must not produce a result
    jres = 32'hdeadbeef; jv = 1'b1;
    @(negedge clk);
    jv = 1'b0;
    @(negedge clk);
    chk("ignored_valid", {31'b0, o_valid}, 32'h0);
    chk("ignored_res", o_result, last_res);
    // Full FIFO: alu stalled, five accepts (four queued plus one in issue)
    i_alu_ready = 1'b0;
    fix_lat = 0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      push($urandom, 32'($urandom_range(0, 31)), SHL, 1'b1, ok);
      if (ok) acc++;
      if (i == 5) chk("full_ready", {31'b0, ok}, 32'h0);
    end
    chk("full_accepts", acc, 32'd5);
    i_alu_ready = 1'b1;
    drain("full");
    // NOP filter: only the shift reaches the alu
    i0 = issues;
    push(32'h9, 32'h1, 4'h0, 1'b1, ok);
    push(32'h2, 32'h3, SHL, 1'b1, ok);
    drain("nop");
    repeat (3) @(negedge clk);
    chk("nop_issues", issues - i0, 32'h1);
    // Timeout: alu never answers the first op, the queued one proceeds afterwards
    mute = 1'b1;
    fix_lat = 2;
    push(32'h3, 32'h4, SHL, 1'b0, ok);
    push(32'h7, 32'h2, SHL, 1'b1, ok);
    n = 0;
    while (o_alu_cmd == 4'h0 && n < 20) begin @(negedge clk); n++; end
    while (o_alu_cmd != 4'h0 && n < 40) begin @(negedge clk); n++; end
    chk("to_entered_wait", {28'b0, o_alu_cmd}, 32'h0);
    repeat (7) @(negedge clk);
    chk("to_early", {31'b0, o_timeout}, 32'h0);
    @(negedge clk);
    chk("to_flag", {31'b0, o_timeout}, 32'h1);
    chk("to_no_valid", {31'b0, o_valid}, 32'h0);
    chk("to_count", {16'b0, o_count}, {16'b0, exp_count});
    mute = 1'b0;
    drain("to_next");
    chk("to_sticky", {31'b0, o_timeout}, 32'h1);
    // Random traffic with backpressure on both sides
    fix_lat = 0;
    c0 = exp_count;
    sent = 0;
    n = 0;
    while ((sent < 200 || exp_q.size() > 0) && n < 20000) begin
      i_ready = ($urandom_range(0, 2) != 0);
      i_alu_ready = ($urandom_range(0, 3) != 0);
      i_valid = (sent < 200) && ($urandom_range(0, 1) == 1);
      i_cmd = ($urandom_range(0, 7) == 0) ? 4'h0 : SHL;
      i_a = $urandom;
      i_b = 32'($urandom_range(0, 31));
      if (i_valid && o_ready && i_cmd != 4'h0) begin
        exp_q.push_back({i_a << i_b[4:0], i_cmd});
        sent++;
      end
      step_check();
      @(negedge clk);
      n++;
    end
    i_valid = 1'b0; i_ready = 1'b0; i_alu_ready = 1'b1;
    chk("rand_left", exp_q.size(), 32'h0);
    chk("rand_ops", {16'b0, o_count - c0}, 32'd200);
    // Counter wrap from a preset near the top
    force dut.o_count = 16'hfffe;
    @(negedge clk);
    release dut.o_count;
    exp_count = 16'hfffe;
    if (o_count == 16'hfffe) begin
      push($urandom, 32'h4, SHL, 1'b1, ok);
      push($urandom, 32'h1f, SHL, 1'b1, ok);
      drain("wrap");
      chk("wrap_zero", {16'b0, o_count}, 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule
